// File: rtl/gmii_pkg.sv
// Shared GMII video/audio link definitions: receiver state encoding, packet idents,
// CRC-32 constants and header byte offsets (counted from the first byte of each section).
package gmii_pkg;

    typedef enum logic [3:0] {
        IDLE, PRE, ETH, IP, UDP, IDENT, RESOL, PIX, AUXID, AUX, FCS, DROP
    } rx_state_e;

    localparam logic [7:0] ID_VIDEO     = 8'd0;
    localparam logic [7:0] ID_AUDIO     = 8'd1;
    localparam logic [7:0] ID_VIDAX     = 8'd2;

    localparam logic [7:0] PRE_BYTE     = 8'h55;
    localparam logic [7:0] SFD_BYTE     = 8'hD5;
    localparam logic [7:0] IP_PROTO_UDP = 8'h11;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // The first 0x55 is consumed in IDLE, so PRE may see at most six more.
    localparam logic [10:0] PRE_EXTRA_MAX = 11'd6;
    localparam logic [10:0] ETH_MAC_LAST  = 11'd5;
    localparam logic [10:0] ETH_TYPE_HI   = 11'd12;
    localparam logic [10:0] ETH_LAST      = 11'd13;
    localparam logic [10:0] IP_PROTO_OFS  = 11'd9;
    localparam logic [10:0] IP_LAST       = 11'd19;
    localparam logic [10:0] UDP_DPORT_HI  = 11'd2;
    localparam logic [10:0] UDP_DPORT_LO  = 11'd3;
    localparam logic [10:0] UDP_LAST      = 11'd7;
    localparam logic [10:0] FCS_LAST      = 11'd3;

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            default: b = mac[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_crc32.sv
// Byte-wide reflected CRC-32 (poly 0x04C11DB7) over the received frame, with a
// combinational residue check that already includes the byte being accepted.
module rx_crc32
    import gmii_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       init_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic       match_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    assign crc_d = crc32_byte(crc_q, data_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    // The residue constant is quoted in normal bit order; the register runs reflected.
    assign match_o = (bit_rev32(crc_d) == CRC_RESIDUE);

endmodule

// File: rtl/gmii_rx.sv
// GMII receive front end: strips Ethernet/IPv4/UDP headers, filters the frame and
// demultiplexes video pixel pairs and aux bytes into the sink FIFOs.
//  IDLE  | wait for a fresh rx_dv         PRE   | 0x55 run up to SFD
//  ETH   | MAC / ethertype filter         IP    | protocol byte check
//  UDP   | destination port filter        IDENT | packet type byte
//  RESOL | line header word               PIX   | pixel pairs to video FIFO
//  AUXID | aux block header                AUX   | aux bytes to audio FIFO
//  FCS   | CRC residue check              DROP  | ignore until rx_dv falls
module gmii_rx
    import gmii_pkg::*;
#(
    parameter logic [47:0] MY_MAC    = 48'h002345678902,
    parameter logic [15:0] ETH_TYPE  = 16'h0800,
    parameter logic [15:0] UDP_DPORT = 16'd12345,
    parameter logic [10:0] PIX_BYTES = 11'd1200,
    parameter logic [5:0]  AUX_BYTES = 6'd32,
    parameter logic [4:0]  AUX_MAX   = 5'd20
) (
    input  logic        rx_clk,
    input  logic        sys_rst_n,
    input  logic        id,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic        line_hdr_vld,
    output logic [15:0] line_hdr,
    output logic        pix_wr_en,
    output logic [15:0] pix_din,
    input  logic        pix_full,
    output logic        ax_wr_en,
    output logic [23:0] ax_din,
    input  logic        ax_full,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        ovf
);

    localparam logic [10:0] PIX_LAST = PIX_BYTES - 11'd1;
    localparam logic [10:0] AUX_LAST = {5'd0, AUX_BYTES} - 11'd1;

    logic [7:0]  rxd_q;
    logic        dv_q, er_q, armed_q;

    rx_state_e   state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        vidax_q, vidax_d;
    logic [4:0]  blk_q, blk_d;
    logic        last_blk_q, last_blk_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] aux_hdr_q, aux_hdr_d;

    logic        line_hdr_vld_q, line_hdr_vld_d;
    logic [15:0] line_hdr_q, line_hdr_d;
    logic        pix_wr_en_q, pix_wr_en_d;
    logic [15:0] pix_din_q, pix_din_d;
    logic        ax_wr_en_q, ax_wr_en_d;
    logic [23:0] ax_din_q, ax_din_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_ok_q, frame_ok_d;
    logic        ovf_q, ovf_d;

    logic        crc_init, crc_en, crc_match;
    logic [7:0]  mac_exp;
    logic        abort, mismatch;

    rx_crc32 u_crc (
        .clk_i   (rx_clk),
        .rst_n_i (sys_rst_n),
        .init_i  (crc_init),
        .en_i    (crc_en),
        .data_i  (rxd_q),
        .match_o (crc_match)
    );

    assign mac_exp = (cnt_q == ETH_MAC_LAST) ? (MY_MAC[7:0] - {7'd0, id})
                                             : mac_byte(MY_MAC, cnt_q[2:0]);
    assign abort   = !dv_q || er_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        vidax_d        = vidax_q;
        blk_d          = blk_q;
        last_blk_d     = last_blk_q;
        byte_d         = byte_q;
        aux_hdr_d      = aux_hdr_q;
        line_hdr_vld_d = 1'b0;
        line_hdr_d     = line_hdr_q;
        pix_wr_en_d    = 1'b0;
        pix_din_d      = pix_din_q;
        ax_wr_en_d     = 1'b0;
        ax_din_d       = ax_din_q;
        frame_done_d   = 1'b0;
        frame_ok_d     = frame_ok_q;
        ovf_d          = ovf_q;
        crc_init       = 1'b0;
        crc_en         = 1'b0;
        mismatch       = 1'b0;

        case (state_q)
            IDLE: begin
                crc_init = 1'b1;
                if (dv_q && armed_q) begin
                    state_d = (rxd_q == PRE_BYTE) ? PRE : DROP;
                end
            end
            PRE: begin
                crc_init = 1'b1;
                if (abort) begin
                    state_d = DROP;
                end else if (rxd_q == SFD_BYTE) begin
                    state_d = ETH;
                end else if (rxd_q == PRE_BYTE && cnt_q < PRE_EXTRA_MAX) begin
                    cnt_d = cnt_q + 11'd1;
                end else begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!dv_q) state_d = IDLE;
            end
            default: begin
                if (abort) begin
                    if (state_q inside {IDENT, RESOL, PIX, AUXID, AUX, FCS}) begin
                        frame_done_d = 1'b1;
                        frame_ok_d   = 1'b0;
                    end
                    state_d = DROP;
                end else begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_q + 11'd1;
                    case (state_q)
                        ETH: begin
                            if (cnt_q <= ETH_MAC_LAST)     mismatch = (rxd_q != mac_exp);
                            else if (cnt_q == ETH_TYPE_HI) mismatch = (rxd_q != ETH_TYPE[15:8]);
                            else if (cnt_q == ETH_LAST)    mismatch = (rxd_q != ETH_TYPE[7:0]);
                            if (mismatch)               state_d = DROP;
                            else if (cnt_q == ETH_LAST) state_d = IP;
                        end
                        IP: begin
                            mismatch = (cnt_q == IP_PROTO_OFS) && (rxd_q != IP_PROTO_UDP);
                            if (mismatch)              state_d = DROP;
                            else if (cnt_q == IP_LAST) state_d = UDP;
                        end
                        UDP: begin
                            if (cnt_q == UDP_DPORT_HI)      mismatch = (rxd_q != UDP_DPORT[15:8]);
                            else if (cnt_q == UDP_DPORT_LO) mismatch = (rxd_q != UDP_DPORT[7:0]);
                            if (mismatch)               state_d = DROP;
                            else if (cnt_q == UDP_LAST) state_d = IDENT;
                        end
                        IDENT: begin
                            blk_d = 5'd0;
                            case (rxd_q)
                                ID_VIDEO: begin vidax_d = 1'b0; state_d = RESOL; end
                                ID_VIDAX: begin vidax_d = 1'b1; state_d = RESOL; end
                                ID_AUDIO: begin vidax_d = 1'b0; state_d = AUXID; end
                                default:  state_d = DROP;
                            endcase
                        end
                        RESOL: begin
                            if (cnt_q == 11'd0) begin
                                byte_d = rxd_q;
                            end else begin
                                line_hdr_d     = {byte_q, rxd_q};
                                line_hdr_vld_d = 1'b1;
                                state_d        = PIX;
                            end
                        end
                        PIX: begin
                            if (!cnt_q[0]) begin
                                byte_d = rxd_q;
                            end else begin
                                pix_din_d = {byte_q, rxd_q};
                                if (pix_full) ovf_d       = 1'b1;
                                else          pix_wr_en_d = 1'b1;
                            end
                            if (cnt_q == PIX_LAST) state_d = vidax_q ? AUXID : FCS;
                        end
                        AUXID: begin
                            if (cnt_q == 11'd0) begin
                                byte_d = rxd_q;
                            end else if (blk_q == AUX_MAX) begin
                                frame_done_d = 1'b1;
                                frame_ok_d   = 1'b0;
                                state_d      = DROP;
                            end else begin
                                aux_hdr_d  = {byte_q, rxd_q};
                                last_blk_d = (rxd_q[7:3] <= 5'd1);
                                blk_d      = blk_q + 5'd1;
                                state_d    = AUX;
                            end
                        end
                        AUX: begin
                            ax_din_d = {aux_hdr_q, rxd_q};
                            if (ax_full) ovf_d      = 1'b1;
                            else         ax_wr_en_d = 1'b1;
                            if (cnt_q == AUX_LAST) state_d = last_blk_q ? FCS : AUXID;
                        end
                        FCS: begin
                            if (cnt_q == FCS_LAST) begin
                                frame_done_d = 1'b1;
                                frame_ok_d   = crc_match;
                                state_d      = DROP;
                            end
                        end
                        default: state_d = DROP;
                    endcase
                end
            end
        endcase

        if (state_d != state_q) cnt_d = 11'd0;
    end

    always_ff @(posedge rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_q          <= 8'd0;
            dv_q           <= 1'b0;
            er_q           <= 1'b0;
            armed_q        <= 1'b0;
            state_q        <= IDLE;
            cnt_q          <= 11'd0;
            vidax_q        <= 1'b0;
            blk_q          <= 5'd0;
            last_blk_q     <= 1'b0;
            byte_q         <= 8'd0;
            aux_hdr_q      <= 16'd0;
            line_hdr_vld_q <= 1'b0;
            line_hdr_q     <= 16'd0;
            pix_wr_en_q    <= 1'b0;
            pix_din_q      <= 16'd0;
            ax_wr_en_q     <= 1'b0;
            ax_din_q       <= 24'd0;
            frame_done_q   <= 1'b0;
            frame_ok_q     <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            rxd_q          <= rxd;
            dv_q           <= rx_dv;
            er_q           <= rx_er;
            // A frame may only start once rx_dv has been seen low after reset.
            armed_q        <= armed_q | ~dv_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            vidax_q        <= vidax_d;
            blk_q          <= blk_d;
            last_blk_q     <= last_blk_d;
            byte_q         <= byte_d;
            aux_hdr_q      <= aux_hdr_d;
            line_hdr_vld_q <= line_hdr_vld_d;
            line_hdr_q     <= line_hdr_d;
            pix_wr_en_q    <= pix_wr_en_d;
            pix_din_q      <= pix_din_d;
            ax_wr_en_q     <= ax_wr_en_d;
            ax_din_q       <= ax_din_d;
            frame_done_q   <= frame_done_d;
            frame_ok_q     <= frame_ok_d;
            ovf_q          <= ovf_d;
        end
    end

    assign line_hdr_vld = line_hdr_vld_q;
    assign line_hdr     = line_hdr_q;
    assign pix_wr_en    = pix_wr_en_q;
    assign pix_din      = pix_din_q;
    assign ax_wr_en     = ax_wr_en_q;
    assign ax_din       = ax_din_q;
    assign frame_done   = frame_done_q;
    assign frame_ok     = frame_ok_q;
    assign ovf          = ovf_q;

endmodule
